add_seq_ctrl: RTL and testbench

Multi-precision add/subtract sequencer that reuses a single `add8` byte adder over several clock cycles to form an `8*NBYTES`-bit result. It latches the operands on a start pulse and feeds one byte pair per cycle into `add8`, least-significant byte first. The byte carry is registered between cycles. Completion is reported with a one-cycle `done` pulse. It sits between a host (register file or test sequencer) and the shared `add8` datapath.

---
 rtl/add_seq_pkg.sv | 13 +
 rtl/add8.sv | 13 +
 rtl/add_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_add_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add8.sv
// Byte-wide ripple adder shared by the sequencer.
module add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic       co,
    output logic [7:0] s
);

    // Single 8-bit ripple: the only combinational arithmetic per cycle.
    assign {co, s} = 9'(a) + 9'(b) + 9'(ci);

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one byte pair per cycle through a
// single add8, least-significant byte first, carry registered between bytes.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// RUN   | one byte per edge through add8, result written progressively
// DONE  | one-cycle done pulse, then back to IDLE
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  ci,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   s,
    output logic                  co
);

    localparam int              IW   = $clog2(NBYTES);
    localparam logic [IW-1:0]   LAST = IW'(NBYTES - 1);

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [8*NBYTES-1:0]    a_q, a_d;
    logic [8*NBYTES-1:0]    b_q, b_d;
    logic [8*NBYTES-1:0]    s_q, s_d;
    logic                   op_q, op_d;
    logic                   cy_q, cy_d;
    logic                   co_q, co_d;

    logic [7:0]             a_byte, b_byte, b_byte_eff, add_s;
    logic                   add_co;

    assign a_byte     = a_q[{idx_q, 3'b000} +: 8];
    assign b_byte     = b_q[{idx_q, 3'b000} +: 8];
    // Subtraction is a + ~b + 1; the +1 comes from the preset carry.
    assign b_byte_eff = (op_q == OP_SUB) ? ~b_byte : b_byte;

    add8 u_add8 (
        .a  (a_byte),
        .b  (b_byte_eff),
        .ci (cy_q),
        .co (add_co),
        .s  (add_s)
    );

    // Next-state logic: operand capture, byte stepping and result write-back.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        op_d    = op_q;
        cy_d    = cy_q;
        co_d    = co_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cy_d    = (op == OP_SUB) ? 1'b1 : ci;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[{idx_q, 3'b000} +: 8] = add_s;
                cy_d = add_co;
                if (idx_q == LAST) begin
                    // Final carry published with the last byte so it is valid with done.
                    co_d    = add_co;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            op_q    <= 1'b0;
            cy_q    <= 1'b0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            op_q    <= op_d;
            cy_q    <= cy_d;
            co_q    <= co_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign co   = co_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl: directed checks on a 4-byte instance,
// randomized regressions on 2-byte and 8-byte instances.
module tb_add_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;

    always #5 clk = ~clk;

    // 4-byte instance (directed)
    logic        st4 = 0, op4 = 0, ci4 = 0, busy4, done4, co4;
    logic [31:0] a4 = 0, b4 = 0, s4;
    // 2-byte instance (random)
    logic        st2 = 0, op2 = 0, ci2 = 0, busy2, done2, co2;
    logic [15:0] a2 = 0, b2 = 0, s2;
    // 8-byte instance (random)
    logic        st8 = 0, op8 = 0, ci8 = 0, busy8, done8, co8;
    logic [63:0] a8 = 0, b8 = 0, s8;

    add_seq_ctrl #(.NBYTES(4)) dut4 (
        .clk(clk), .rst(rst4), .start(st4), .op(op4), .a(a4), .b(b4), .ci(ci4),
        .busy(busy4), .done(done4), .s(s4), .co(co4)
    );
    add_seq_ctrl #(.NBYTES(2)) dut2 (
        .clk(clk), .rst(rst), .start(st2), .op(op2), .a(a2), .b(b2), .ci(ci2),
        .busy(busy2), .done(done2), .s(s2), .co(co2)
    );
    add_seq_ctrl #(.NBYTES(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .op(op8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .s(s8), .co(co8)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [64:0] q4[$];
    logic [64:0] q2[$];
    logic [64:0] q8[$];
    logic [64:0] last4 = '0;

    // Reference: plain modular arithmetic on nb-byte numbers, {carry, result}.
    function automatic logic [64:0] model(input logic o, input logic [63:0] x,
                                          input logic [63:0] y, input logic c,
                                          input int nb);
        logic [127:0] m, xa, ya, r;
        logic         cout;
        m  = (128'd1 << (8 * nb)) - 128'd1;
        xa = {64'd0, x} & m;
        ya = {64'd0, y} & m;
        if (o == 1'b0) begin
            r    = xa + ya + {127'd0, c};
            cout = r[8 * nb];
        end else begin
            r    = xa - ya;
            cout = (xa >= ya);
        end
        r = r & m;
        return {cout, r[63:0]};
    endfunction

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors: pop the expected result whenever an instance reports done.
    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL dut4 unexpected done: got done=1 expected no pending operation");
            end else begin
                chk("dut4 result", {co4, 32'h0, s4}, q4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL dut2 unexpected done: got done=1 expected no pending operation");
            end else begin
                chk("dut2 result", {co2, 48'h0, s2}, q2.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL dut8 unexpected done: got done=1 expected no pending operation");
            end else begin
                chk("dut8 result", {co8, s8}, q8.pop_front());
            end
        end
    end

    // One directed operation on the 4-byte instance; optionally injects stray
    // starts at E2 and in the DONE cycle, both of which must be ignored.
    task automatic run4(input logic o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic c, input bit inject);
        logic [64:0] e;
        int          cnt;
        int          k;
        @(negedge clk);
        op4 = o; a4 = aa; b4 = bb; ci4 = c; st4 = 1'b1;
        e = model(o, {32'h0, aa}, {32'h0, bb}, c, 4);
        q4.push_back(e);
        @(negedge clk);
        st4 = 1'b0; a4 = $urandom; b4 = $urandom; op4 = ~o; ci4 = ~c;
        chk("dut4 result held before first byte", {co4, 32'h0, s4}, last4);
        cnt = 0;
        k   = 0;
        while (!done4 && k < 20) begin
            if (busy4) cnt++;
            if (inject && k == 1) begin
                st4 = 1'b1; a4 = 32'hDEAD_BEEF; b4 = 32'h0BAD_F00D;
            end else begin
                st4 = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        chk("dut4 busy cycles", 65'(cnt), 65'd4);
        chk("dut4 done reached", {64'h0, done4}, 65'd1);
        if (inject) begin
            st4 = 1'b1; a4 = 32'h7777_7777; b4 = 32'h1111_1111; op4 = 1'b1;
        end
        @(negedge clk);
        st4 = 1'b0;
        chk("dut4 done single cycle", {64'h0, done4}, 65'd0);
        chk("dut4 idle after done", {64'h0, busy4}, 65'd0);
        chk("dut4 result held after done", {co4, 32'h0, s4}, e);
        last4 = e;
    endtask

    // Reset between E2 and E3: outputs clear at once and no done follows.
    task automatic reset_mid4(input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        op4 = 1'b0; a4 = aa; b4 = bb; ci4 = 1'b0; st4 = 1'b1;
        q4.push_back(model(1'b0, {32'h0, aa}, {32'h0, bb}, 1'b0, 4));
        @(negedge clk);
        st4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        #1;
        chk("dut4 reset clears busy/done/co/s", {30'h0, busy4, done4, co4, s4}, 65'd0);
        q4.delete();
        last4 = '0;
        @(negedge clk);
        rst4 = 1'b0;
        repeat (8) @(negedge clk);
        chk("dut4 idle after aborted run", {63'h0, busy4, done4}, 65'd0);
    endtask

    task automatic directed4();
        run4(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run4(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run4(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
        run4(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
        run4(1'b0, 32'h0000_1234, 32'h0000_4321, 1'b0, 1'b1);
        run4(1'b0, 32'h8000_0001, 32'h8000_0001, 1'b1, 1'b0);
        reset_mid4(32'h0F0F_0F0F, 32'h0101_0101);
        run4(1'b1, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 1'b0);
    endtask

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = '1;
            1:       v = '0;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic random2(input int nops);
        logic [63:0] x, y;
        logic        o, c;
        int          k;
        for (int i = 0; i < nops; i++) begin
            @(negedge clk);
            x = rnd_operand(); y = ($urandom_range(0, 7) == 0) ? x : rnd_operand();
            o = 1'($urandom); c = 1'($urandom);
            a2 = x[15:0]; b2 = y[15:0]; op2 = o; ci2 = c; st2 = 1'b1;
            q2.push_back(model(o, x, y, c, 2));
            @(negedge clk);
            k = 0;
            while (!done2 && k < 20) begin
                st2 = ($urandom_range(0, 3) == 0);
                a2 = 16'($urandom); b2 = 16'($urandom); op2 = 1'($urandom); ci2 = 1'($urandom);
                @(negedge clk);
                k++;
            end
            if (!done2) begin
                chk("dut2 done within bound", {64'h0, done2}, 65'd1);
                break;
            end
            st2 = 1'($urandom);
            @(negedge clk);
            st2 = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic random8(input int nops);
        logic [63:0] x, y;
        logic        o, c;
        int          k;
        for (int i = 0; i < nops; i++) begin
            @(negedge clk);
            x = rnd_operand(); y = ($urandom_range(0, 7) == 0) ? x : rnd_operand();
            o = 1'($urandom); c = 1'($urandom);
            a8 = x; b8 = y; op8 = o; ci8 = c; st8 = 1'b1;
            q8.push_back(model(o, x, y, c, 8));
            @(negedge clk);
            k = 0;
            while (!done8 && k < 30) begin
                st8 = ($urandom_range(0, 3) == 0);
                a8 = {$urandom, $urandom}; b8 = {$urandom, $urandom};
                op8 = 1'($urandom); ci8 = 1'($urandom);
                @(negedge clk);
                k++;
            end
            if (!done8) begin
                chk("dut8 done within bound", {64'h0, done8}, 65'd1);
                break;
            end
            st8 = 1'($urandom);
            @(negedge clk);
            st8 = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("dut4 reset state", {30'h0, busy4, done4, co4, s4}, 65'd0);
        chk("dut2 reset state", {46'h0, busy2, done2, co2, s2}, 65'd0);
        chk("dut8 reset state", {busy8 | done8 | co8, s8}, 65'd0);
        rst  = 1'b0;
        rst4 = 1'b0;
        fork
            directed4();
            random2(1000);
            random8(1000);
        join
        repeat (4) @(negedge clk);
        chk("dut4 scoreboard drained", 65'(q4.size()), 65'd0);
        chk("dut2 scoreboard drained", 65'(q2.size()), 65'd0);
        chk("dut8 scoreboard drained", 65'(q8.size()), 65'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_chk);
        $fatal(1, "time limit");
    end

endmodule
